// File: rtl/switch_debounce_sync_pkg.sv
// rtl/switch_debounce_sync_pkg.sv - shared board constants for switch conditioning
//
// Purpose: board clock and debounce-time constants. The default debounce
//          length in cycles is derived from these values, so retargeting
//          to a different board clock only needs an edit here.
// Ports:   none (package)
package switch_debounce_sync_pkg;

  localparam int CLK_FREQ_HZ = 50_000_000;
  localparam int DEBOUNCE_MS = 20;

  function automatic int cycles_for_ms(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  // 20 ms at 50 MHz -> 1_000_000 cycles
  localparam int DEBOUNCE_CYCLES_DEFAULT = cycles_for_ms(CLK_FREQ_HZ, DEBOUNCE_MS);

endpackage

// File: rtl/switch_debounce_sync_debounce_bit.sv
// rtl/switch_debounce_sync_debounce_bit.sv - one-bit synchronizer, debounce filter and edge strobes
//
// Purpose: brings one raw switch level into Clk, accepts a new level only
//          after it has persisted for DEBOUNCE_CYCLES consecutive edges,
//          and strobes Rise/Fall for one cycle when the clean level flips.
// Ports:   Clk   - system clock, rising edge
//          Reset - synchronous, active-high
//          Din   - raw asynchronous level
//          Dout  - debounced, synchronized level
//          Rise  - one-cycle pulse on Dout 0->1
//          Fall  - one-cycle pulse on Dout 1->0
module debounce_bit
  import switch_debounce_sync_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Din,
  output logic Dout,
  output logic Rise,
  output logic Fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   sync_out;

  assign sync_out = sync[SYNC_STAGES-1];

  // cnt==0 is the STABLE state, cnt>0 is COUNTING; there is no separate
  // state register. The counter is cleared as soon as the synchronized
  // input agrees with Dout again, so a bounce restarts qualification and
  // cnt can never pass CNT_LAST.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync <= '0;
      cnt  <= '0;
      Dout <= 1'b0;
      Rise <= 1'b0;
      Fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], Din};
      Rise <= 1'b0;
      Fall <= 1'b0;
      if (sync_out == Dout) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        Dout <= sync_out;
        cnt  <= '0;
        Rise <= sync_out;
        Fall <= ~sync_out;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/switch_debounce_sync.sv
// rtl/switch_debounce_sync.sv - multi-bit switch/key synchronizer and debouncer
//
// Purpose: conditions WIDTH raw board switch/key inputs into clean levels
//          plus single-cycle Rise/Fall strobes usable as clock enables.
// Ports:   Clk     - system clock, rising edge
//          Reset   - synchronous, active-high
//          Din     - [WIDTH] raw asynchronous levels
//          Dout    - [WIDTH] debounced, synchronized levels
//          Rise    - [WIDTH] one-cycle pulse on Dout 0->1
//          Fall    - [WIDTH] one-cycle pulse on Dout 1->0
//          Changed - OR of all Rise and Fall bits in the same cycle
module switch_debounce_sync
  import switch_debounce_sync_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Dout,
  output logic [WIDTH-1:0] Rise,
  output logic [WIDTH-1:0] Fall,
  output logic             Changed
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce_bit (
      .Clk   (Clk),
      .Reset (Reset),
      .Din   (Din[i]),
      .Dout  (Dout[i]),
      .Rise  (Rise[i]),
      .Fall  (Fall[i])
    );
  end

  // Built from registered strobes, so it stays glitch-free.
  assign Changed = |(Rise | Fall);

endmodule

// File: tb/tb_switch_debounce_sync.sv
// tb/tb_switch_debounce_sync.sv - bench for switch_debounce_sync
module tb_switch_debounce_sync;

  localparam int W    = 2;
  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout, rise, fall;
  logic         changed;

  int vectors = 0;
  int miscompares = 0;
  bit compare_en = 1'b0;

  switch_debounce_sync #(
    .WIDTH           (W),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .Clk     (clk),
    .Reset   (reset),
    .Din     (din),
    .Dout    (dout),
    .Rise    (rise),
    .Fall    (fall),
    .Changed (changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a raw level reaches the filter SYNC edges after it is
  // sampled; the clean level flips once the last DEB filter inputs seen
  // since reset all disagree with it.
  logic [W-1:0] din_q[$];
  logic [W-1:0] so_q[$];
  logic [W-1:0] m_dout = '0, m_rise = '0, m_fall = '0;

  always @(posedge clk) begin
    logic [W-1:0] so;
    if (reset) begin
      din_q.delete();
      so_q.delete();
      m_dout = '0;
      m_rise = '0;
      m_fall = '0;
    end else begin
      so = (din_q.size() == SYNC) ? din_q.pop_front() : '0;
      din_q.push_back(din);
      so_q.push_back(so);
      if (so_q.size() > DEB) void'(so_q.pop_front());
      m_rise = '0;
      m_fall = '0;
      for (int b = 0; b < W; b++) begin
        bit all_differ;
        all_differ = (so_q.size() == DEB);
        for (int j = 0; j < so_q.size(); j++)
          if (so_q[j][b] == m_dout[b]) all_differ = 1'b0;
        if (all_differ) begin
          m_dout[b] = ~m_dout[b];
          m_rise[b] = m_dout[b];
          m_fall[b] = ~m_dout[b];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (compare_en) begin
      check("model_dout", dout, m_dout);
      check("model_rise", rise, m_rise);
      check("model_fall", fall, m_fall);
      check("model_changed", changed, |(m_rise | m_fall));
      check("rise_and_fall_exclusive", rise & fall, 0);
    end
  end

  task automatic step(input logic r, input logic [W-1:0] d);
    reset = r;
    din = d;
    @(negedge clk);
  endtask

  int rise1_count;

  initial begin
    // 1: reset held 3 cycles with Din=11
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b11);
      compare_en = 1'b1;
      check("rst_dout", dout, 2'b00);
      check("rst_rise", rise, 2'b00);
      check("rst_fall", fall, 2'b00);
      check("rst_changed", changed, 1'b0);
    end
    // 2: Din[0] rises before edge 0 and holds -> update on edge 5
    for (int e = 0; e <= 6; e++) begin
      step(1'b0, 2'b01);
      check("s2_dout", dout, (e >= 5) ? 2'b01 : 2'b00);
      check("s2_rise", rise, (e == 5) ? 2'b01 : 2'b00);
      check("s2_changed", changed, (e == 5));
    end
    // 3: 3-cycle glitch on Din[1] is rejected
    for (int e = 0; e < 12; e++) begin
      step(1'b0, (e < 3) ? 2'b11 : 2'b01);
      check("s3_dout", dout, 2'b01);
      check("s3_changed", changed, 1'b0);
    end
    // 4: both high then both low together
    for (int e = 0; e <= 6; e++) begin
      step(1'b0, 2'b11);
      check("s4_dout_hi", dout, (e >= 5) ? 2'b11 : 2'b01);
      check("s4_rise", rise, (e == 5) ? 2'b10 : 2'b00);
    end
    for (int e = 0; e <= 6; e++) begin
      step(1'b0, 2'b00);
      check("s4_dout_lo", dout, (e >= 5) ? 2'b00 : 2'b11);
      check("s4_fall", fall, (e == 5) ? 2'b11 : 2'b00);
      check("s4_changed", changed, (e == 5));
    end
    for (int e = 0; e < 4; e++) step(1'b0, 2'b00);
    // 5: reset at count 2, Rise re-qualifies 5 edges after release
    for (int e = 0; e < 4; e++) step(1'b0, 2'b01);
    step(1'b1, 2'b01);
    check("s5_rst_dout", dout, 2'b00);
    check("s5_rst_fall", fall, 2'b00);
    for (int e = 0; e <= 6; e++) begin
      step(1'b0, 2'b01);
      check("s5_dout", dout, (e >= 5) ? 2'b01 : 2'b00);
      check("s5_rise", rise, (e == 5) ? 2'b01 : 2'b00);
    end
    // reset while Dout=1: silent drop
    step(1'b1, 2'b01);
    check("s5b_dout", dout, 2'b00);
    check("s5b_fall", fall, 2'b00);
    check("s5b_changed", changed, 1'b0);
    for (int e = 0; e < 8; e++) step(1'b0, 2'b00);
    // 6: bounce 1,0,1,0,1 then hold -> one Rise, 5 edges after last 0->1
    rise1_count = 0;
    for (int e = 0; e < 16; e++) begin
      logic [4:0] pat;
      pat = 5'b10101;
      step(1'b0, {(e >= 5) ? 1'b1 : pat[4 - e], 1'b0});
      if (rise[1]) rise1_count++;
      check("s6_dout", dout, (e >= 9) ? 2'b10 : 2'b00);
      check("s6_rise", rise, (e == 9) ? 2'b10 : 2'b00);
    end
    check("s6_rise_count", rise1_count, 1);
    // randomized phase, checked against the model every cycle
    for (int i = 0; i < 4000; i++) begin
      logic [W-1:0] d;
      d = din;
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 5) == 0) d[b] = ~d[b];
      step(($urandom_range(0, 299) == 0), d);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
